// File: rtl/add_pipe_nbit_if.sv
// Handshake and data bundle for add_pipe_nbit.
// The master side supplies operands and accepts results; the slave side is the adder.
interface add_pipe_nbit_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/add_pipe_nbit.sv
// add_pipe_nbit: pipelined N-bit adder/subtractor with valid/ready handshake.
// The operands are split into STAGES chunks of W = N/STAGES bits; stage i adds
// chunk i and passes its carry to stage i+1 through a register, so one result
// leaves per cycle after STAGES cycles of latency. N must be a multiple of STAGES.
// Optional feature macro: ADD_PIPE_SAT_EN (unsigned saturation of sum; the
// c_out and ovf flags stay raw).
module add_pipe_nbit #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    add_pipe_nbit_if.slave bus
);
    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    // Per-stage registers: operands travel alongside the partial sum so the
    // upper chunks are available when their stage is reached.
    logic         v_q   [STAGES];
    logic         c_q   [STAGES];
    logic         sub_q [STAGES];
    logic [N-1:0] a_q   [STAGES];
    logic [N-1:0] b_q   [STAGES];
    logic [N-1:0] s_q   [STAGES];
    logic         ovf_q;

    logic         v_d   [STAGES];
    logic         c_d   [STAGES];
    logic         sub_d [STAGES];
    logic [N-1:0] a_d   [STAGES];
    logic [N-1:0] b_d   [STAGES];
    logic [N-1:0] s_d   [STAGES];

    logic         stall;
    logic         advance;
    logic         ovf_d;
    logic [N-1:0] out_sum_d;

    // A held result freezes the whole pipeline, so in_ready depends only on
    // the output handshake and never on in_valid.
    assign stall         = v_q[L] && !bus.out_ready;
    assign advance       = !stall;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[L];
    assign bus.sum       = s_q[L];
    assign bus.c_out     = c_q[L];
    assign bus.ovf       = ovf_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [N-1:0] a_in;
            logic [N-1:0] b_in;
            logic [N-1:0] s_in;
            logic         c_in;
            logic         v_in;
            logic         sub_in;
            logic [W:0]   part;
            logic [N-1:0] s_mix;

            if (gi == 0) begin : g_head
                // Subtraction is a + ~b + 1: invert B and feed sub as carry-in.
                assign a_in   = bus.a;
                assign b_in   = bus.b ^ {N{bus.sub}};
                assign s_in   = '0;
                assign c_in   = bus.sub;
                assign v_in   = bus.in_valid;
                assign sub_in = bus.sub;
            end else begin : g_body
                assign a_in   = a_q[gi-1];
                assign b_in   = b_q[gi-1];
                assign s_in   = s_q[gi-1];
                assign c_in   = c_q[gi-1];
                assign v_in   = v_q[gi-1];
                assign sub_in = sub_q[gi-1];
            end

            assign part = {1'b0, a_in[gi*W +: W]} + {1'b0, b_in[gi*W +: W]} + {{W{1'b0}}, c_in};

            // Drop this stage's chunk into the skewed partial-sum word.
            always_comb begin
                s_mix              = s_in;
                s_mix[gi*W +: W]   = part[W-1:0];
            end

            assign a_d[gi]   = a_in;
            assign b_d[gi]   = b_in;
            assign s_d[gi]   = s_mix;
            assign c_d[gi]   = part[W];
            assign v_d[gi]   = v_in;
            assign sub_d[gi] = sub_in;
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b' ^ cin.
    assign ovf_d = a_d[L][N-1] ^ b_d[L][N-1] ^ s_d[L][N-1] ^ c_d[L];

`ifdef ADD_PIPE_SAT_EN
    // Clamp to all-ones on unsigned add overflow, to zero on subtract borrow.
    always_comb begin
        out_sum_d = s_d[L];
        if (!sub_d[L] && c_d[L]) begin
            out_sum_d = '1;
        end else if (sub_d[L] && !c_d[L]) begin
            out_sum_d = '0;
        end
    end
`else
    assign out_sum_d = s_d[L];
`endif

    // Pipeline advance: everything holds on stall; bubbles move but leave data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i]   <= 1'b0;
                c_q[i]   <= 1'b0;
                sub_q[i] <= 1'b0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                s_q[i]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= v_d[i];
                if (v_d[i]) begin
                    c_q[i]   <= c_d[i];
                    sub_q[i] <= sub_d[i];
                    a_q[i]   <= a_d[i];
                    b_q[i]   <= b_d[i];
                    s_q[i]   <= (i == L) ? out_sum_d : s_d[i];
                end
            end
            if (v_d[L]) begin
                ovf_q <= ovf_d;
            end
        end
    end
endmodule

// File: doc/add_pipe_nbit.md
# add_pipe_nbit

Pipelined, parametrised N-bit adder/subtractor with valid/ready handshake; next generation of the combinational `add_Nbit`. Splits the operand into STAGES equal chunks, one chunk per clock, carry rippling stage-to-stage through registers, giving one result per cycle at high clock rates. Sits between operand registers and the writeback path of the CPU datapath.

## Interface
- N, 8, operand/result width; must be a multiple of STAGES.
- STAGES, 2, pipeline depth and chunk count (1..N); chunk width W = N/STAGES.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  N  operand A (unsigned or two's complement).
- b  in  N  operand B.
- sub  in  1  0 = a+b, 1 = a-b.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  N  result, mod 2^N (saturated under ADD_PIPE_SAT_EN).
- c_out  out  1  carry out of bit N-1; for subtract 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.

## Operation
- Operand B is inverted when sub=1; stage-0 carry-in = sub.
- Stage i (0..STAGES-1) adds chunk i of A and B' plus registered carry from stage i-1; it registers its W-bit partial sum, its carry, and the not-yet-consumed upper chunks of A and B' plus sub.
- Lower partial sums are forwarded, skewed, so all chunks of one operation reach the output together.
- Final stage also produces c_out = carry out of bit N-1 and ovf = carry into bit N-1 XOR carry out of bit N-1.
- Each stage holds a valid bit; bubbles propagate as invalid entries and never update outputs.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. While stalled, every pipeline register (data and valid) holds; in_ready = !stall.
- STAGES=1: single registered adder, latency 1, same handshake.

## Timing
- Reset (rst high at a clock edge): all valid bits 0, out_valid 0, sum 0, c_out 0, ovf 0, all internal data registers 0. in_ready is 1 in the cycle following reset.
- rst has priority over any transfer in the same cycle; operations in flight when reset is asserted are discarded, never emitted.
- Latency: operands accepted at edge k produce out_valid=1 with their result after edge k+STAGES-1 (visible during cycle k+STAGES) if no stall occurs.
- Throughput: one operation per cycle when out_ready stays high.
- Stall adds latency cycle-for-cycle; results are never dropped, duplicated or reordered.
- in_ready is combinational from out_ready and out_valid only (no path from in_valid).
- Simultaneous out transfer and in transfer in a cycle: both occur, pipeline advances.
- sum/c_out/ovf are stable while out_valid=1 and out_ready=0.

## Configuration
- ADD_PIPE_SAT_EN defined: unsigned saturation on sum. Add with c_out=1 yields all ones; subtract with c_out=0 (borrow) yields 0; otherwise sum unchanged. c_out and ovf remain the raw unsaturated flags. No extra latency.
- ADD_PIPE_SAT_EN undefined: sum is the wrapped result mod 2^N; no saturation logic present.

## Test plan
- N=8, STAGES=2, out_ready=1: a=111, b=100, sub=0 -> after 2 cycles sum=211, c_out=0, ovf=1.
- a=255, b=1, sub=0 -> sum=0, c_out=1, ovf=0 (ADD_PIPE_SAT_EN: sum=255).
- a=5, b=7, sub=1 -> sum=254, c_out=0, ovf=0 (ADD_PIPE_SAT_EN: sum=0); a=7, b=5, sub=1 -> sum=2, c_out=1.
- Back-to-back 0+0, 1+1 ... 9+9 with in_valid held high -> in_ready stays 1, outputs 0,2,...,18 on ten consecutive cycles.
- Stream of 5 operations with out_ready held low for 3 cycles mid-stream -> in_ready low exactly while out_valid=1 and out_ready=0; sum held steady; all 5 results emitted in order, none lost.
- Assert rst for one cycle with 2 operations in flight -> next cycle out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1; discarded operations never appear; a new operation completes with normal latency.
